dac_sample_scheduler: RTL and testbench
=======================================

DAC_SAMPLE_SCHEDULER -- requirements
Module: dac_sample_scheduler

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, the sample width in bits; it matches the modulator data width.
REQ-002 SHALL have parameter NUM_REQ, default 2, the number of sample requesters (2..8).
REQ-003 SHALL have parameter OSR_W, default 8, the width of the oversampling period input.
REQ-004 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-005 SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-006 SHALL have port enable, input, 1 bit: run/stop of sample scheduling.
REQ-007 SHALL have port osr_period, input, OSR_W bits: clocks per sample slot.
REQ-008 SHALL have port req_valid, input, NUM_REQ bits: per-requester sample available.
REQ-009 SHALL have port req_data, input, NUM_REQ*DATA_SIZE bits: per-requester sample, where requester i occupies slice i.
REQ-010 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept strobe.
REQ-011 SHALL have port mod_data, output, DATA_SIZE bits: sample driven to the modulator data input.
REQ-012 SHALL have port mod_load, output, 1 bit: one-cycle strobe marking a new mod_data.
REQ-013 SHALL have port mod_ch, output, $clog2(NUM_REQ) bits: requester index of the current mod_data, used for the external output demux.
REQ-014 SHALL have port underrun, output, 1 bit: one-cycle strobe when a slot ends with no sample available.
REQ-015 SHALL have port underrun_cnt, output, 16 bits: saturating count of underrun events.

Function
REQ-016 SHALL implement states IDLE and RUN.
REQ-017 IDLE->RUN SHALL occur when enable=1; RUN->IDLE SHALL occur on the cycle after enable=0, regardless of slot progress.
REQ-018 On entry to RUN, the slot counter SHALL be 0, so the first acceptance opportunity is the first RUN cycle.
REQ-019 In RUN, the slot counter SHALL reload to eff_period-1 when it is 0 and decrement otherwise.
REQ-020 eff_period SHALL be max(osr_period,1); osr_period SHALL be sampled only at reload.
REQ-021 req_ready[i] SHALL be 1 only when state=RUN, counter=0 and grant[i]=1; it is at most one-hot and may depend combinationally on req_valid.
REQ-022 The grant SHALL be round-robin: the search starts at pointer p; after a grant to requester i, p SHALL become (i+1) mod NUM_REQ; p SHALL be unchanged when no requester is granted.
REQ-023 An accept SHALL occur in cycle T when req_valid[i]&req_ready[i]; at T+1, mod_data=req_data slice i, mod_ch=i and mod_load=1 for exactly one cycle.
REQ-024 If counter=0 in RUN and req_valid=0, then at T+1 underrun SHALL be 1 for one cycle, underrun_cnt SHALL increment, saturating at 16'hFFFF, and mod_data/mod_ch SHALL hold.
REQ-025 mod_data SHALL be stable between mod_load strobes.
REQ-026 On the RUN->IDLE transition, mod_data SHALL become MIDSCALE (1<<(DATA_SIZE-1)) with mod_load=1 for one cycle; in IDLE, req_ready SHALL be 0 and no underrun SHALL be counted.
REQ-027 A req_valid change in a non-zero counter cycle SHALL have no effect.
REQ-028 With osr_period=1, an accept or underrun evaluation SHALL occur every RUN cycle.

Reset
REQ-029 While reset=0 at a clk edge, the block SHALL enter: state=IDLE, counter=0, p=0, mod_data=MIDSCALE, mod_load=0, mod_ch=0, underrun=0, underrun_cnt=0, req_ready=0.
REQ-030 Reset asserted mid-slot SHALL abandon the slot; no accept SHALL be reported for the reset cycle.

Structure
REQ-031 Package dac_pkg SHALL hold the state enum (IDLE, RUN) and the MIDSCALE function/constant of DATA_SIZE.
REQ-032 Round-robin grant logic SHALL be a separate sub-module rr_arbiter (inputs: valid vector, pointer; output: one-hot grant), purely combinational; the pointer register is held in dac_sample_scheduler.

Verification
REQ-033 Reset then idle: reset=0 for 3 cycles, enable=0 -> mod_data=32'h8000_0000, req_ready=0, underrun_cnt=0.
REQ-034 Single requester: enable=1, osr_period=4, req_valid=2'b01 held, data 32'h1234_5678 -> req_ready[0] pulses every 4 cycles; mod_load follows 1 cycle later; mod_ch=0.
REQ-035 Round-robin: both requesters valid, osr_period=3 -> grants alternate 0,1,0,1; mod_ch follows the same order; p wraps 1->0.
REQ-036 Underrun: osr_period=5, req_valid=0 for 3 slots -> 3 underrun pulses spaced 5 cycles apart, underrun_cnt=3, mod_data unchanged.
REQ-037 Disable mid-slot: osr_period=8, deassert enable at counter=4 -> the next cycle has state IDLE, mod_data=MIDSCALE and mod_load=1; later req_valid produces no req_ready.
REQ-038 Edge cases: osr_period=0 -> behaves as 1, with an accept every cycle; reset asserted during RUN -> all REQ-029 values on the next cycle.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample scheduler.
package dac_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int MAX_DATA_SIZE = 256;

    // Mid-scale code (only the MSB set) for a sample of the given width; callers slice the low bits.
    function automatic logic [MAX_DATA_SIZE-1:0] midscale(input int data_size);
        return MAX_DATA_SIZE'(1) << (data_size - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr wins.
module rr_arbiter #(
    parameter int N    = 2,
    parameter int PW   = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces requester samples into a modulator at one sample slot per eff_period clocks,
// arbitrating requesters round-robin and flagging slots that find no sample.
module dac_sample_scheduler
    import dac_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int NUM_REQ   = 2,
    parameter int OSR_W     = 8,
    localparam int CH_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [OSR_W-1:0]             osr_period,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_SIZE-1:0]         mod_data,
    output logic                         mod_load,
    output logic [CH_W-1:0]              mod_ch,
    output logic                         underrun,
    output logic [15:0]                  underrun_cnt,
    output state_t                       state
);

    localparam logic [MAX_DATA_SIZE-1:0] MID_WIDE = midscale(DATA_SIZE);
    localparam logic [DATA_SIZE-1:0]     MIDSCALE = MID_WIDE[DATA_SIZE-1:0];

    // Handshake: a sample transfers in any cycle where req_valid[i] and req_ready[i] are both high;
    // req_ready is offered only in slot cycles and never waits on anything but the slot counter.
    state_t            state_next;
    logic [OSR_W-1:0]  cnt;
    logic [OSR_W-1:0]  eff_period;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic              slot;
    logic              leaving;
    logic              accept;

    rr_arbiter #(.N(NUM_REQ), .PW(CH_W)) u_arb (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Slot work is suppressed in the last RUN cycle so the mid-scale park is never racing a sample.
    always_comb begin
        slot      = (state == RUN) && enable && (cnt == '0);
        leaving   = (state == RUN) && !enable;
        req_ready = slot ? grant : '0;
        accept    = |(req_valid & req_ready);
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = CH_W'(i);
        end
    end

    assign eff_period = (osr_period == '0) ? OSR_W'(1) : osr_period;

    always_ff @(posedge clk) begin
        if (!reset)                         cnt <= '0;
        else if (slot)                      cnt <= eff_period - OSR_W'(1);
        else if ((state == RUN) && enable)  cnt <= cnt - OSR_W'(1);
        else                                cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            ptr <= '0;
        else if (accept)
            ptr <= (grant_idx == CH_W'(NUM_REQ - 1)) ? '0 : grant_idx + CH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mod_data     <= MIDSCALE;
            mod_load     <= 1'b0;
            mod_ch       <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            mod_load <= 1'b0;
            underrun <= 1'b0;
            if (leaving) begin
                mod_data <= MIDSCALE;
                mod_load <= 1'b1;
            end else if (accept) begin
                mod_data <= req_data[grant_idx*DATA_SIZE +: DATA_SIZE];
                mod_ch   <= grant_idx;
                mod_load <= 1'b1;
            end else if (slot && (req_valid == '0)) begin
                underrun <= 1'b1;
                if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed bench for dac_sample_scheduler: each scenario task drives vectors and checks hand-computed values.
module tb_dac_sample_scheduler;
    import dac_pkg::*;

    localparam logic [31:0] MID = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  osr_period = '0;
    logic [1:0]  req_valid = '0;
    logic [63:0] req_data = '0;
    logic [1:0]  req_ready;
    logic [31:0] mod_data;
    logic        mod_load;
    logic [0:0]  mod_ch;
    logic        underrun;
    logic [15:0] underrun_cnt;
    state_t      state;

    int errors = 0;
    int checks = 0;

    dac_sample_scheduler #(.DATA_SIZE(32), .NUM_REQ(2), .OSR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .osr_period   (osr_period),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .mod_data     (mod_data),
        .mod_load     (mod_load),
        .mod_ch       (mod_ch),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; req_valid = '0; osr_period = '0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic stop_run();
        enable = 1'b0; req_valid = '0;
        tick(); #1;
        checks++; if (state !== IDLE) begin errors++; $display("FAIL stop_state got=%0d exp=%0d", state, IDLE); end
        checks++; if (mod_data !== MID) begin errors++; $display("FAIL stop_mod_data got=%h exp=%h", mod_data, MID); end
        checks++; if (mod_load !== 1'b1) begin errors++; $display("FAIL stop_mod_load got=%b exp=1", mod_load); end
        tick(); #1;
        checks++; if (mod_load !== 1'b0) begin errors++; $display("FAIL stop_load_drop got=%b exp=0", mod_load); end
    endtask

    task automatic test_reset();
        do_reset(); #1;
        checks++; if (mod_data !== MID) begin errors++; $display("FAIL reset_mod_data got=%h exp=%h", mod_data, MID); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_underrun_cnt got=%0d exp=0", underrun_cnt); end
        checks++; if (mod_load !== 1'b0) begin errors++; $display("FAIL reset_mod_load got=%b exp=0", mod_load); end
        checks++; if (mod_ch !== 1'b0) begin errors++; $display("FAIL reset_mod_ch got=%0d exp=0", mod_ch); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        checks++; if (state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state, IDLE); end
        req_valid = 2'b11; osr_period = 8'd1;
        repeat (2) tick();
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL idle_req_ready got=%b exp=00", req_ready); end
        checks++; if (state !== IDLE) begin errors++; $display("FAIL idle_state got=%0d exp=%0d", state, IDLE); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL idle_underrun_cnt got=%0d exp=0", underrun_cnt); end
    endtask

    task automatic test_single_requester();
        logic [1:0] exp_ready;
        logic       exp_load;
        do_reset();
        osr_period = 8'd4; req_valid = 2'b01; req_data = {32'hAAAA_AAAA, 32'h1234_5678};
        enable = 1'b1;
        tick();
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_ready = (c % 4 == 0) ? 2'b01 : 2'b00;
            exp_load  = (c % 4 == 1);
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
            checks++; if (mod_load !== exp_load) begin errors++; $display("FAIL single_load c=%0d got=%b exp=%b", c, mod_load, exp_load); end
            checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL single_underrun c=%0d got=%b exp=0", c, underrun); end
            if (exp_load) begin
                checks++; if (mod_data !== 32'h1234_5678) begin errors++; $display("FAIL single_data c=%0d got=%h exp=12345678", c, mod_data); end
                checks++; if (mod_ch !== 1'b0) begin errors++; $display("FAIL single_ch c=%0d got=%0d exp=0", c, mod_ch); end
            end
            tick();
        end
        stop_run();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ready;
        logic [31:0] exp_data;
        int          k;
        do_reset();
        osr_period = 8'd3; req_data = {32'hB1B1_0002, 32'hA0A0_0001};
        enable = 1'b1;
        tick();
        for (int c = 0; c < 14; c++) begin
            // Off-slot cycles wiggle req_valid, which must not disturb the grant sequence.
            req_valid = (c % 3 == 0) ? 2'b11 : ((c % 2 == 1) ? 2'b00 : 2'b10);
            #1;
            exp_ready = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b10 : 2'b01);
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
            checks++; if (mod_load !== (c % 3 == 1)) begin errors++; $display("FAIL rr_load c=%0d got=%b exp=%b", c, mod_load, (c % 3 == 1)); end
            if (c % 3 == 1) begin
                k = (c - 1) / 3;
                exp_data = (k % 2 == 1) ? 32'hB1B1_0002 : 32'hA0A0_0001;
                checks++; if (mod_ch !== 1'(k % 2)) begin errors++; $display("FAIL rr_ch c=%0d got=%0d exp=%0d", c, mod_ch, k % 2); end
                checks++; if (mod_data !== exp_data) begin errors++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, mod_data, exp_data); end
            end
            tick();
        end
        stop_run();
    endtask

    task automatic test_underrun();
        int         exp_cnt;
        logic       exp_under;
        logic [31:0] exp_data;
        do_reset();
        osr_period = 8'd5; req_data = {32'h0000_0000, 32'hCAFE_F00D};
        enable = 1'b1;
        exp_cnt = 0;
        tick();
        for (int c = 0; c < 18; c++) begin
            req_valid = (c == 0) ? 2'b01 : 2'b00;
            #1;
            exp_under = (c >= 6) && ((c - 1) % 5 == 0);
            if (exp_under) exp_cnt++;
            exp_data = (c == 0) ? MID : 32'hCAFE_F00D;
            checks++; if (underrun !== exp_under) begin errors++; $display("FAIL ur_pulse c=%0d got=%b exp=%b", c, underrun, exp_under); end
            checks++; if (underrun_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL ur_cnt c=%0d got=%0d exp=%0d", c, underrun_cnt, exp_cnt); end
            checks++; if (mod_load !== (c == 1)) begin errors++; $display("FAIL ur_load c=%0d got=%b exp=%b", c, mod_load, (c == 1)); end
            checks++; if (mod_data !== exp_data) begin errors++; $display("FAIL ur_data c=%0d got=%h exp=%h", c, mod_data, exp_data); end
            tick();
        end
        stop_run();
        repeat (3) tick();
        #1;
        checks++; if (underrun_cnt !== 16'd3) begin errors++; $display("FAIL ur_cnt_idle got=%0d exp=3", underrun_cnt); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_idle_pulse got=%b exp=0", underrun); end
    endtask

    task automatic test_disable_mid_slot();
        do_reset();
        osr_period = 8'd8; req_valid = 2'b01; req_data = {32'h0000_0000, 32'h0BAD_BEEF};
        enable = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (req_ready !== ((c == 0) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL dis_ready c=%0d got=%b", c, req_ready); end
            if (c == 1) begin
                checks++; if (mod_data !== 32'h0BAD_BEEF) begin errors++; $display("FAIL dis_data got=%h exp=0badbeef", mod_data); end
            end
            tick();
        end
        enable = 1'b0;
        #1;
        checks++; if (state !== RUN) begin errors++; $display("FAIL dis_still_run got=%0d exp=%0d", state, RUN); end
        tick(); #1;
        checks++; if (state !== IDLE) begin errors++; $display("FAIL dis_state got=%0d exp=%0d", state, IDLE); end
        checks++; if (mod_data !== MID) begin errors++; $display("FAIL dis_mod_data got=%h exp=%h", mod_data, MID); end
        checks++; if (mod_load !== 1'b1) begin errors++; $display("FAIL dis_mod_load got=%b exp=1", mod_load); end
        req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            tick(); #1;
            checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL dis_idle_ready c=%0d got=%b exp=00", c, req_ready); end
            checks++; if (mod_load !== 1'b0) begin errors++; $display("FAIL dis_idle_load c=%0d got=%b exp=0", c, mod_load); end
        end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL dis_idle_cnt got=%0d exp=0", underrun_cnt); end
        req_valid = 2'b00;
    endtask

    task automatic test_osr_zero();
        logic [31:0] exp_data;
        do_reset();
        osr_period = 8'd0; req_valid = 2'b11; req_data = {32'h2222_2222, 32'h1111_1111};
        enable = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (req_ready !== ((c % 2 == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL osr0_ready c=%0d got=%b", c, req_ready); end
            if (c >= 1) begin
                exp_data = ((c - 1) % 2 == 1) ? 32'h2222_2222 : 32'h1111_1111;
                checks++; if (mod_load !== 1'b1) begin errors++; $display("FAIL osr0_load c=%0d got=%b exp=1", c, mod_load); end
                checks++; if (mod_ch !== 1'((c - 1) % 2)) begin errors++; $display("FAIL osr0_ch c=%0d got=%0d exp=%0d", c, mod_ch, (c - 1) % 2); end
                checks++; if (mod_data !== exp_data) begin errors++; $display("FAIL osr0_data c=%0d got=%h exp=%h", c, mod_data, exp_data); end
            end
            tick();
        end
        stop_run();
    endtask

    task automatic test_reset_in_run();
        do_reset();
        osr_period = 8'd3; req_data = {32'h3333_3333, 32'h4444_4444};
        enable = 1'b1;
        tick();
        for (int c = 0; c < 7; c++) begin
            req_valid = (c == 0) ? 2'b10 : ((c == 6) ? 2'b11 : 2'b00);
            if (c == 6) reset = 1'b0;
            #1;
            if (c == 4) begin
                checks++; if (mod_ch !== 1'b1) begin errors++; $display("FAIL rst_pre_ch got=%0d exp=1", mod_ch); end
                checks++; if (underrun_cnt !== 16'd1) begin errors++; $display("FAIL rst_pre_cnt got=%0d exp=1", underrun_cnt); end
            end
            tick();
        end
        #1;
        checks++; if (state !== IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", state, IDLE); end
        checks++; if (mod_data !== MID) begin errors++; $display("FAIL rst_mod_data got=%h exp=%h", mod_data, MID); end
        checks++; if (mod_load !== 1'b0) begin errors++; $display("FAIL rst_mod_load got=%b exp=0", mod_load); end
        checks++; if (mod_ch !== 1'b0) begin errors++; $display("FAIL rst_mod_ch got=%0d exp=0", mod_ch); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
        checks++; if (underrun_cnt !== 16'd0) begin errors++; $display("FAIL rst_underrun_cnt got=%0d exp=0", underrun_cnt); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got=%b exp=00", req_ready); end
        reset = 1'b1; enable = 1'b0; req_valid = 2'b00;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single_requester();
        test_round_robin();
        test_underrun();
        test_disable_mid_slot();
        test_osr_zero();
        test_reset_in_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
